sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO buffer, the next generation of the team's FIFO block. It has configurable data width and depth, a selectable standard or first-word-fall-through (FWFT) read mode, a programmable fill-level threshold, sticky overflow and underflow flags with explicit clear, and a synchronous flush. It sits between a producer and a consumer that share one clock domain, and it is the drop-in buffer for datapaths that do not need clock-domain crossing.

## Interface
- DATA_W, 8, data word width in bits
- DEPTH, 64, number of entries; power of two, ≥ 4
- ADDR_W, $clog2(DEPTH), pointer width (derived; do not override)
- FWFT, 0, 0 = standard read (registered, 1-cycle latency); 1 = first-word-fall-through
- clk  in  1  single clock, rising-edge active
- rst  in  1  asynchronous, active-low reset
- buf_in  in  DATA_W  write data
- wr_en  in  1  write request
- rd_en  in  1  read request (FWFT: acknowledge/pop the head word)
- flush  in  1  synchronous empty-the-FIFO
- clr_flags  in  1  synchronous clear of of_check and uf_check
- thresh_in  in  ADDR_W+1  fill-level threshold, 0..DEPTH
- buf_out  out  DATA_W  read data
- buf_empty  out  1  fifo_counter == 0
- buf_full  out  1  fifo_counter == DEPTH
- fifo_counter  out  ADDR_W+1  current occupancy, 0..DEPTH
- thresh_out  out  1  fifo_counter >= thresh_in
- of_check  out  1  sticky overflow flag
- uf_check  out  1  sticky underflow flag

## Operation
- Storage is a DEPTH x DATA_W register array, with wr_ptr and rd_ptr of ADDR_W bits each. Pointers wrap naturally from DEPTH-1 to 0.
- Accepted read: rd_ok = rd_en && !buf_empty.
- Accepted write: wr_ok = wr_en && (!buf_full || rd_ok).
  - When full, a simultaneous read and write are both accepted and the count is unchanged.
- When empty, a simultaneous read and write accept the write only. The read is rejected and uf_check is set.
- Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- Overflow: wr_en && !wr_ok sets of_check. The data is dropped and nothing else changes.
- Underflow: rd_en && buf_empty sets uf_check. Pointers and buf_out are unchanged.
- Flag set and clear:
  - Both flags hold until clr_flags.
  - If a set and clr_flags occur in the same cycle, the set wins.
- Flush:
  - Priority is flush > rd/wr.
  - Flush clears wr_ptr, rd_ptr and fifo_counter.
  - wr_en and rd_en are ignored that cycle and set no flags.
  - of_check, uf_check and the storage contents are untouched.
- Standard mode (FWFT=0): buf_out is registered and loads mem[rd_ptr] on rd_ok. Otherwise it holds, including across a flush.
- FWFT mode (FWFT=1):
  - buf_out = mem[rd_ptr] combinationally.
  - It is valid whenever buf_empty = 0; its value is don't-care when empty.
  - rd_ok advances to the next word.
- thresh_out is combinational from the registered count and thresh_in.
  - thresh_in = 0 makes it always 1.
  - thresh_in > DEPTH makes it always 0.
  - It follows thresh_in changes in the same cycle.

## Timing
- Reset values: buf_out = 0, buf_empty = 1, buf_full = 0, fifo_counter = 0, of_check = 0, uf_check = 0, pointers = 0, thresh_out = (thresh_in == 0).
- Reset is asynchronous: assertion clears state immediately, mid-operation, with no clock needed. Any in-flight write is lost.
- Deassertion: the first active edge after rst rises may already accept a write.
- Write latency: a word written at edge N is in storage after N.
  - buf_empty, buf_full, fifo_counter and thresh_out update after N.
- Standard-mode read latency: rd_ok at edge N puts data on buf_out after N (1 cycle).
- FWFT-mode read latency: after a write into an empty FIFO at edge N, buf_empty falls and buf_out shows the word after N. There is no extra cycle.
- of_check and uf_check assert after the edge of the offending request.
- Flush takes effect after its edge. buf_empty = 1 the cycle after.
- All status outputs are glitch-free registered values except thresh_out and FWFT buf_out.

## Test plan
- **Reset, fill and drain (FWFT=0, DEPTH=64):**
  - Stimulus: after reset, 64 writes of 0x00..0x3F.
  - Required: fifo_counter = 64, buf_full = 1, of_check = 0.
  - Stimulus: then 64 reads.
  - Required: buf_out equals 0x00..0x3F, each 1 cycle after its rd_en; buf_empty = 1 at end.
- **Overflow and underflow:**
  - Stimulus: with the FIFO full, write 0xAA.
  - Required: of_check = 1, count stays 64, 0xAA never read.
  - Stimulus: after draining, read from empty.
  - Required: uf_check = 1, buf_out holds.
  - Stimulus: clr_flags.
  - Required: both flags 0.
  - Stimulus: clr_flags in the same cycle as a new overflow.
  - Required: of_check = 1.
- **Simultaneous read and write at boundaries:**
  - Stimulus: full plus rd_en and wr_en together.
  - Required: both accepted, count 64, no of_check.
  - Stimulus: empty plus both together.
  - Required: count 1, uf_check = 1.
  - Stimulus: 200 random-interleaved operations against a scoreboard, crossing pointer wrap at least 3 times.
  - Required: no data mismatch.
- **FWFT=1:**
  - Stimulus: write 0x5C into an empty FIFO.
  - Required: buf_empty = 0 and buf_out = 0x5C the cycle after the write, with no rd_en.
  - Stimulus: rd_en.
  - Required: the next word is presented, or buf_empty = 1.
- **Threshold:**
  - Stimulus: thresh_in = 15, fill.
  - Required: thresh_out rises exactly when the count reaches 15.
  - Stimulus: change thresh_in to 30 mid-fill at count 20.
  - Required: thresh_out drops the same cycle.
  - Stimulus: thresh_in = 0.
  - Required: thresh_out = 1 even when empty.
- **Flush and asynchronous reset mid-operation:**
  - Stimulus: at count 37, flush with wr_en = 1.
  - Required: count 0, buf_empty = 1, no flags changed, flushed write dropped.
  - Stimulus: refill to 10, then pulse rst low between clock edges.
  - Required: all outputs at reset values immediately.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// fill-level threshold, sticky overflow/underflow flags and synchronous flush.
module sync_fifo_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] buf_in,
  input  logic              wr_en,
  input  logic              rd_en,
  input  logic              flush,
  input  logic              clr_flags,
  input  logic [ADDR_W:0]   thresh_in,
  output logic [DATA_W-1:0] buf_out,
  output logic              buf_empty,
  output logic              buf_full,
  output logic [ADDR_W:0]   fifo_counter,
  output logic              thresh_out,
  output logic              of_check,
  output logic              uf_check
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              of_q, of_d;
  logic              uf_q, uf_d;
  logic              rd_ok, wr_ok, mem_we;
  logic              of_set, uf_set;

  always_comb begin
    rd_ok    = rd_en && (count_q != '0);
    // A full FIFO still takes a write when a read frees the slot in the same cycle.
    wr_ok    = wr_en && ((count_q != FULL_CNT) || rd_ok);
    of_set   = !flush && wr_en && !wr_ok;
    uf_set   = !flush && rd_en && !rd_ok;
    mem_we   = !flush && wr_ok;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        dout_d   = mem_q[rd_ptr_q];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
    // Set beats clear when both happen in the same cycle.
    of_d = of_set || (of_q && !clr_flags);
    uf_d = uf_set || (uf_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      of_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      of_q     <= of_d;
      uf_q     <= uf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= buf_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so reset reads as 0.
      assign buf_out = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      assign buf_out = dout_q;
    end
  endgenerate

  assign buf_empty    = (count_q == '0);
  assign buf_full     = (count_q == FULL_CNT);
  assign fifo_counter = count_q;
  assign thresh_out   = (count_q >= thresh_in);
  assign of_check     = of_q;
  assign uf_check     = uf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a standard-mode DEPTH=64 instance and a
// small FWFT instance, checked against a queue model after every clock edge.
module tb_sync_fifo_param;

  logic       clk;
  logic       rst;
  logic [7:0] buf_in;
  logic       wr_en, rd_en, flush, clr_flags;
  logic [6:0] thresh_in;
  logic [7:0] buf_out;
  logic       buf_empty, buf_full, thresh_out, of_check, uf_check;
  logic [6:0] fifo_counter;

  logic [7:0] buf_in_f, buf_out_f;
  logic       wr_en_f, rd_en_f;
  logic [2:0] thresh_in_f, fifo_counter_f;
  logic       buf_empty_f, buf_full_f, thresh_out_f, of_check_f, uf_check_f;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] sb_q[$];
  logic [7:0] fq[$];
  logic [7:0] m_out;
  logic       m_of, m_uf;

  sync_fifo_param #(.DATA_W(8), .DEPTH(64), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .buf_in(buf_in), .wr_en(wr_en), .rd_en(rd_en),
    .flush(flush), .clr_flags(clr_flags), .thresh_in(thresh_in),
    .buf_out(buf_out), .buf_empty(buf_empty), .buf_full(buf_full),
    .fifo_counter(fifo_counter), .thresh_out(thresh_out),
    .of_check(of_check), .uf_check(uf_check)
  );

  sync_fifo_param #(.DATA_W(8), .DEPTH(4), .FWFT(1)) u_dut_fwft (
    .clk(clk), .rst(rst), .buf_in(buf_in_f), .wr_en(wr_en_f), .rd_en(rd_en_f),
    .flush(1'b0), .clr_flags(1'b0), .thresh_in(thresh_in_f),
    .buf_out(buf_out_f), .buf_empty(buf_empty_f), .buf_full(buf_full_f),
    .fifo_counter(fifo_counter_f), .thresh_out(thresh_out_f),
    .of_check(of_check_f), .uf_check(uf_check_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},   32'(buf_out), 32'(m_out));
    check({tag, ".cnt"},   32'(fifo_counter), 32'(sb_q.size()));
    check({tag, ".empty"}, 32'(buf_empty), 32'(sb_q.size() == 0));
    check({tag, ".full"},  32'(buf_full), 32'(sb_q.size() == 64));
    check({tag, ".thr"},   32'(thresh_out), 32'(sb_q.size() >= int'(thresh_in)));
    check({tag, ".of"},    32'(of_check), 32'(m_of));
    check({tag, ".uf"},    32'(uf_check), 32'(m_uf));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".out"},   32'(buf_out), 32'h0);
    check({tag, ".empty"}, 32'(buf_empty), 32'h1);
    check({tag, ".full"},  32'(buf_full), 32'h0);
    check({tag, ".cnt"},   32'(fifo_counter), 32'h0);
    check({tag, ".of"},    32'(of_check), 32'h0);
    check({tag, ".uf"},    32'(uf_check), 32'h0);
    check({tag, ".thr"},   32'(thresh_out), 32'(thresh_in == 0));
    check({tag, ".f_empty"}, 32'(buf_empty_f), 32'h1);
    check({tag, ".f_out"},   32'(buf_out_f), 32'h0);
  endtask

  // One clock of the standard-mode instance, model updated from pre-edge state.
  task automatic step(input string tag, input logic w, input logic r, input logic [7:0] d,
                      input logic fl, input logic cf);
    int   n;
    logic rd_acc, wr_acc, of_set, uf_set;
    n      = sb_q.size();
    rd_acc = !fl && r && (n != 0);
    wr_acc = !fl && w && ((n < 64) || rd_acc);
    of_set = !fl && w && !wr_acc;
    uf_set = !fl && r && (n == 0);
    wr_en = w; rd_en = r; buf_in = d; flush = fl; clr_flags = cf;
    @(posedge clk); #1;
    if (fl) sb_q.delete();
    else begin
      if (rd_acc) m_out = sb_q.pop_front();
      if (wr_acc) sb_q.push_back(d);
    end
    m_of = of_set || (m_of && !cf);
    m_uf = uf_set || (m_uf && !cf);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_flags = 1'b0;
    check_all(tag);
    $display("%0t %s wr=%0b rd=%0b fl=%0b cf=%0b din=%02h -> out=%02h cnt=%0d of=%0b uf=%0b",
             $time, tag, w, r, fl, cf, d, buf_out, fifo_counter, of_check, uf_check);
  endtask

  task automatic fstep(input string tag, input logic w, input logic r, input logic [7:0] d);
    logic rd_acc;
    rd_acc = r && (fq.size() != 0);
    wr_en_f = w; rd_en_f = r; buf_in_f = d;
    @(posedge clk); #1;
    if (rd_acc) void'(fq.pop_front());
    if (w && ((fq.size() < 4) || rd_acc)) fq.push_back(d);
    wr_en_f = 1'b0; rd_en_f = 1'b0;
    check({tag, ".f_empty"}, 32'(buf_empty_f), 32'(fq.size() == 0));
    check({tag, ".f_cnt"},   32'(fifo_counter_f), 32'(fq.size()));
    if (fq.size() != 0) check({tag, ".f_out"}, 32'(buf_out_f), 32'(fq[0]));
    $display("%0t %s fwft wr=%0b rd=%0b din=%02h -> out=%02h empty=%0b",
             $time, tag, w, r, d, buf_out_f, buf_empty_f);
  endtask

  initial begin
    rst = 1'b0; buf_in = '0; wr_en = 0; rd_en = 0; flush = 0; clr_flags = 0;
    thresh_in = '0; buf_in_f = '0; wr_en_f = 0; rd_en_f = 0; thresh_in_f = '0;
    m_out = '0; m_of = 0; m_uf = 0;
    #12;
    check_reset("reset");
    thresh_in = 7'd15; #1;
    check("thr_reset15", 32'(thresh_out), 32'h0);
    @(negedge clk) rst = 1'b1;

    for (int i = 0; i < 20; i++) step("fill", 1, 0, 8'(i), 0, 0);
    thresh_in = 7'd30; #1;
    check("thr_mid30", 32'(thresh_out), 32'h0);
    for (int i = 20; i < 64; i++) step("fill", 1, 0, 8'(i), 0, 0);
    thresh_in = 7'd15;

    step("full_rw", 1, 1, 8'h40, 0, 0);
    step("ovf", 1, 0, 8'hAA, 0, 0);
    for (int i = 0; i < 64; i++) step("drain", 0, 1, 8'h00, 0, 0);
    step("unf", 0, 1, 8'h00, 0, 0);
    step("clr", 0, 0, 8'h00, 0, 1);
    step("empty_rw", 1, 1, 8'h11, 0, 0);
    step("rd11", 0, 1, 8'h00, 0, 0);

    for (int i = 0; i < 64; i++) step("fill2", 1, 0, 8'($urandom), 0, 0);
    step("ovf_clr", 1, 0, 8'hBB, 0, 1);

    step("flush0", 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 37; i++) step("fill37", 1, 0, 8'(i + 100), 0, 0);
    step("flush_wr", 1, 0, 8'h99, 1, 0);
    step("post_flush", 0, 0, 8'h00, 0, 0);

    for (int i = 0; i < 300; i++)
      step("rand", $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 60, 8'($urandom), 0, 0);

    thresh_in = 7'd0;
    step("flush1", 0, 0, 8'h00, 1, 0);
    check("thr_zero_empty", 32'(thresh_out), 32'h1);

    fstep("fwft_w5c", 1, 0, 8'h5C);
    fstep("fwft_w5d", 1, 0, 8'h5D);
    fstep("fwft_rd1", 0, 1, 8'h00);
    fstep("fwft_rd2", 0, 1, 8'h00);

    thresh_in = 7'd15;
    for (int i = 0; i < 10; i++) step("refill", 1, 0, 8'(i + 200), 0, 0);
    fstep("fwft_pre", 1, 0, 8'h33);
    #2 rst = 1'b0;
    #1 check_reset("async_rst");
    sb_q.delete(); fq.delete(); m_out = '0; m_of = 0; m_uf = 0;
    @(negedge clk) rst = 1'b1;
    step("first_wr", 1, 0, 8'h77, 0, 0);
    step("first_rd", 0, 1, 8'h00, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
